// File: rtl/bp_me_stream_collector_if.sv
// ---------------------------------------------------------------------------
// bp_me_stream_collector_if
//
// Purpose: one BedRock message channel (header + data with a valid/ready-and
// handshake). The collector uses one instance as its narrow beat input and a
// second, wider instance as its collected-message output.
//
// Parameters:
//   header_width_p  width of the BedRock xce header
//   data_width_p    width of the data field carried on this channel
//
// Signals:
//   msg_header     header (driven by master)
//   msg_data       data (driven by master)
//   msg_v          valid (driven by master)
//   msg_ready_and  ready; transfer when msg_v & msg_ready_and (driven by slave)
//
// Modports:
//   master  producer side
//   slave   consumer side
// ---------------------------------------------------------------------------
interface bp_me_stream_collector_if
  #(parameter int header_width_p = 111
  , parameter int data_width_p   = 64
  );

  logic [header_width_p-1:0] msg_header;
  logic [data_width_p-1:0]   msg_data;
  logic                      msg_v;
  logic                      msg_ready_and;

  modport master (output msg_header, output msg_data, output msg_v, input  msg_ready_and);
  modport slave  (input  msg_header, input  msg_data, input  msg_v, output msg_ready_and);

endinterface

// File: rtl/bp_me_stream_collector.sv
// ---------------------------------------------------------------------------
// bp_me_stream_collector
//
// Purpose: gathers a multi-beat BedRock stream (header repeated on every
// beat, narrow data beats) into a single message with one header and one
// full-width data word. Message types whose stream_mask_p bit is clear are
// collected as a single beat.
//
// Header layout (LSB first):
//   [3:0]                       msg_type
//   [6:4]                       size (log2 bytes, 0..7)
//   [7 +: paddr_width_p]        addr
//   [7+paddr_width_p +: payload_width_p] payload
//
// Parameters:
//   paddr_width_p     physical address width from the processor configuration
//   in_data_width_p   beat width (power of two, >= 8)
//   out_data_width_p  collected width (power-of-two multiple, >= 2x beat)
//   payload_width_p   header payload width
//   stream_mask_p     one bit per msg_type; 1 = multi-beat data
//
// Ports:
//   clk_i      clock
//   reset_n_i  synchronous active-low reset; forces all outputs to 0 while low
//   msg_in     slave side of the narrow beat channel
//   msg_out    master side of the wide collected-message channel
//
// Build option:
//   BP_ME_STREAM_COLLECTOR_BYPASS_EN - when defined, a new first beat may be
//   accepted in the same cycle the collected message is taken (len cycles per
//   message). When undefined, FULL always returns through IDLE (len+1 cycles).
// ---------------------------------------------------------------------------
module bp_me_stream_collector
  #(parameter int          paddr_width_p    = 40
  , parameter int          in_data_width_p  = 64
  , parameter int          out_data_width_p = 512
  , parameter int          payload_width_p  = 64
  , parameter logic [15:0] stream_mask_p    = 16'h0000
  )
  (input  logic                      clk_i
  , input logic                      reset_n_i
  , bp_me_stream_collector_if.slave  msg_in
  , bp_me_stream_collector_if.master msg_out
  );

  localparam int ratio_lp     = out_data_width_p / in_data_width_p;
  localparam int cnt_width_lp = $clog2(ratio_lp);
  localparam int in_shift_lp  = $clog2(in_data_width_p);
  localparam int header_width_lp = 4 + 3 + paddr_width_p + payload_width_p;

  typedef enum logic [1:0] {
    e_idle    = 2'd0,
    e_collect = 2'd1,
    e_full    = 2'd2
  } state_e;

  state_e                      r_state, w_state_n;
  logic [cnt_width_lp-1:0]     r_cnt, w_cnt_n;
  logic [cnt_width_lp-1:0]     r_last, w_last_n;
  logic [header_width_lp-1:0]  r_header, w_header_n;
  logic [out_data_width_p-1:0] r_data, w_data_n;

  logic [3:0]              w_type;
  logic [2:0]              w_size;
  logic [10:0]             w_bits;
  logic [10:0]             w_beats;
  logic                    w_stream;
  logic                    w_len_illegal;
  logic [cnt_width_lp-1:0] w_first_last;
  logic                    w_ready;
  logic                    w_accept;
  logic                    w_load_first;

  // Decode beat count (as len-1) from the incoming header.
  always_comb begin
    w_type        = msg_in.msg_header[3:0];
    w_size        = msg_in.msg_header[6:4];
    w_bits        = 11'd8 << w_size;
    w_beats       = w_bits >> in_shift_lp;
    w_stream      = stream_mask_p[w_type];
    w_len_illegal = w_stream && (w_beats > 11'(ratio_lp));
    if (!w_stream || (w_beats <= 11'd1)) begin
      w_first_last = '0;
    end else if (w_len_illegal) begin
      // Oversized requests are clamped to a full output word.
      w_first_last = cnt_width_lp'(ratio_lp - 1);
    end else begin
      w_first_last = cnt_width_lp'(w_beats - 11'd1);
    end
  end

  // Input ready: registered state only, unless bypass lets FULL follow the consumer.
  always_comb begin
`ifdef BP_ME_STREAM_COLLECTOR_BYPASS_EN
    if (r_state == e_full) begin
      w_ready = msg_out.msg_ready_and;
    end else begin
      w_ready = 1'b1;
    end
`else
    if (r_state == e_full) begin
      w_ready = 1'b0;
    end else begin
      w_ready = 1'b1;
    end
`endif
  end

  assign msg_in.msg_ready_and = reset_n_i & w_ready;
  assign w_accept             = msg_in.msg_v & msg_in.msg_ready_and;

  // Next-state and datapath update.
  always_comb begin
    w_state_n    = r_state;
    w_cnt_n      = r_cnt;
    w_last_n     = r_last;
    w_header_n   = r_header;
    w_data_n     = r_data;
    w_load_first = 1'b0;

    case (r_state)
      e_idle: begin
        if (w_accept) begin
          w_load_first = 1'b1;
        end else begin
          w_state_n = e_idle;
        end
      end
      e_collect: begin
        if (w_accept) begin
          // Header on continuation beats is intentionally ignored.
          w_data_n[r_cnt*in_data_width_p +: in_data_width_p] = msg_in.msg_data;
          w_cnt_n = r_cnt + cnt_width_lp'(1);
          if (r_cnt == r_last) begin
            w_state_n = e_full;
          end else begin
            w_state_n = e_collect;
          end
        end else begin
          w_state_n = e_collect;
        end
      end
      e_full: begin
        if (msg_out.msg_ready_and) begin
          w_state_n = e_idle;
`ifdef BP_ME_STREAM_COLLECTOR_BYPASS_EN
          // A beat taken alongside the output transfer starts the next message.
          if (w_accept) begin
            w_load_first = 1'b1;
          end else begin
            w_load_first = 1'b0;
          end
`endif
        end else begin
          w_state_n = e_full;
        end
      end
      default: begin
        w_state_n = e_idle;
      end
    endcase

    if (w_load_first) begin
      w_header_n = msg_in.msg_header;
      w_data_n   = '0;
      w_data_n[0 +: in_data_width_p] = msg_in.msg_data;
      w_cnt_n    = cnt_width_lp'(1);
      w_last_n   = w_first_last;
      if (w_first_last == '0) begin
        w_state_n = e_full;
      end else begin
        w_state_n = e_collect;
      end
    end else begin
      w_header_n = w_header_n;
    end
  end

  // State, counter and buffer registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_state  <= e_idle;
      r_cnt    <= '0;
      r_last   <= '0;
      r_header <= '0;
      r_data   <= '0;
    end else begin
      r_state  <= w_state_n;
      r_cnt    <= w_cnt_n;
      r_last   <= w_last_n;
      r_header <= w_header_n;
      r_data   <= w_data_n;
    end
  end

  assign msg_out.msg_v      = reset_n_i & (r_state == e_full);
  assign msg_out.msg_header = reset_n_i ? r_header : '0;
  assign msg_out.msg_data   = reset_n_i ? r_data   : '0;

  bp_me_stream_collector_chk u_chk
    (.clk_i        (clk_i)
    ,.reset_n_i    (reset_n_i)
    ,.first_beat_i (w_load_first)
    ,.len_illegal_i(w_len_illegal)
    );

endmodule

// ---------------------------------------------------------------------------
// bp_me_stream_collector_chk
//
// Purpose: flags first beats whose requested length exceeds the output word.
//
// Ports:
//   clk_i, reset_n_i  clock and synchronous active-low reset
//   first_beat_i      a first beat is being accepted this cycle
//   len_illegal_i     that beat's decoded length exceeds the output ratio
// ---------------------------------------------------------------------------
module bp_me_stream_collector_chk
  (input  logic clk_i
  , input logic reset_n_i
  , input logic first_beat_i
  , input logic len_illegal_i
  );

  // Oversized stream length on a first beat.
  always_ff @(posedge clk_i) begin
    if (reset_n_i && first_beat_i) begin
      assert (!len_illegal_i);
    end
  end

endmodule

// File: tb/tb_bp_me_stream_collector.sv
module tb_bp_me_stream_collector;

  localparam int IN_W    = 64;
  localparam int OUT_W   = 512;
  localparam int PADDR_W = 40;
  localparam int PAY_W   = 64;
  localparam int HDR_W   = 4 + 3 + PADDR_W + PAY_W;
  localparam logic [15:0] MASK = 16'h0002;
  localparam logic [3:0] T_RD = 4'd0;
  localparam logic [3:0] T_WR = 4'd1;
`ifdef BP_ME_STREAM_COLLECTOR_BYPASS_EN
  localparam int EXP_GAP = 1;
`else
  localparam int EXP_GAP = 2;
`endif

  typedef struct packed {
    logic [HDR_W-1:0] h;
    logic [OUT_W-1:0] d;
  } exp_t;

  logic clk;
  logic reset_n;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   n_xfer = 0;
  exp_t exp_q[$];
  int   xfer_cyc[$];
  exp_t mon_e;

  bp_me_stream_collector_if #(.header_width_p(HDR_W), .data_width_p(IN_W))  in_if ();
  bp_me_stream_collector_if #(.header_width_p(HDR_W), .data_width_p(OUT_W)) out_if ();

  bp_me_stream_collector #(
    .paddr_width_p(PADDR_W), .in_data_width_p(IN_W), .out_data_width_p(OUT_W),
    .payload_width_p(PAY_W), .stream_mask_p(MASK)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n), .msg_in(in_if), .msg_out(out_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [HDR_W-1:0] mk_hdr(input logic [3:0] t, input logic [2:0] s,
                                              input logic [PADDR_W-1:0] a, input logic [PAY_W-1:0] p);
    return {p, a, s, t};
  endfunction

  function automatic void chk(input string name, input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endfunction

  function automatic void chk_i(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endfunction

  // Scoreboard monitor: pops one expected message per output transfer.
  always @(negedge clk) begin
    if (out_if.msg_v === 1'b1 && out_if.msg_ready_and === 1'b1) begin
      n_xfer++;
      xfer_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_xfer actual=%0h required=none", out_if.msg_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("xfer_header", OUT_W'(out_if.msg_header), OUT_W'(mon_e.h));
        chk("xfer_data", out_if.msg_data, mon_e.d);
      end
    end
  end

  task automatic drive_beat(input logic [HDR_W-1:0] h, input logic [IN_W-1:0] d);
    bit done;
    done = 1'b0;
    in_if.msg_header = h;
    in_if.msg_data   = d;
    in_if.msg_v      = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (in_if.msg_ready_and === 1'b1) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    in_if.msg_v = 1'b0;
    chk_i("accept_timeout", int'(done), 1);
  endtask

  // Beat k carries base + k*step; continuation headers carry a shifted addr.
  task automatic send_msg(input logic [3:0] t, input logic [2:0] s, input logic [PADDR_W-1:0] a,
                          input logic [PAY_W-1:0] p, input int n, input logic [IN_W-1:0] base,
                          input logic [IN_W-1:0] step, input int gap);
    for (int k = 0; k < n; k++) begin
      drive_beat(mk_hdr(t, s, a + PADDR_W'(k * 64), p), base + IN_W'(k) * step);
      if (gap > 0 && k < n - 1) begin
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          chk("gap_v_low", OUT_W'(out_if.msg_v), OUT_W'(1'b0));
          chk("gap_ready", OUT_W'(in_if.msg_ready_and), OUT_W'(1'b1));
        end
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"},  OUT_W'(in_if.msg_ready_and), OUT_W'(1'b0));
    chk({tag, "_v"},      OUT_W'(out_if.msg_v), OUT_W'(1'b0));
    chk({tag, "_header"}, OUT_W'(out_if.msg_header), '0);
    chk({tag, "_data"},   out_if.msg_data, '0);
  endtask

  initial begin
    exp_t e;
    int   base_x;
    reset_n = 1'b0;
    in_if.msg_v = 1'b0;
    in_if.msg_header = '0;
    in_if.msg_data = '0;
    out_if.msg_ready_and = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("idle_ready", OUT_W'(in_if.msg_ready_and), OUT_W'(1'b1));
    @(posedge clk); #1;

    // 64B write, eight back-to-back beats 1..8
    e.h = mk_hdr(T_WR, 3'd6, 40'h00_0000_1000, 64'h55);
    e.d = {64'h8, 64'h7, 64'h6, 64'h5, 64'h4, 64'h3, 64'h2, 64'h1};
    exp_q.push_back(e);
    send_msg(T_WR, 3'd6, 40'h00_0000_1000, 64'h55, 8, 64'h1, 64'h1, 0);
    @(negedge clk);
    chk("wr64_latency_v", OUT_W'(out_if.msg_v), OUT_W'(1'b1));
    @(posedge clk); #1;

    // 64B read is not a stream type: one beat
    e.h = mk_hdr(T_RD, 3'd6, 40'h00_0000_2040, 64'h77);
    e.d = 512'hAA;
    exp_q.push_back(e);
    send_msg(T_RD, 3'd6, 40'h00_0000_2040, 64'h77, 1, 64'hAA, 64'h0, 0);
    @(negedge clk);
    chk("rd_latency_v", OUT_W'(out_if.msg_v), OUT_W'(1'b1));
    @(posedge clk); #1;

    // 32B write with 2-cycle gaps
    e.h = mk_hdr(T_WR, 3'd5, 40'h00_0000_3000, 64'h1);
    e.d = {64'h44, 64'h33, 64'h22, 64'h11};
    exp_q.push_back(e);
    send_msg(T_WR, 3'd5, 40'h00_0000_3000, 64'h1, 4, 64'h11, 64'h11, 2);
    @(negedge clk);
    chk("wr32_latency_v", OUT_W'(out_if.msg_v), OUT_W'(1'b1));
    @(posedge clk); #1;

    // Backpressure: consumer not ready for 5 cycles
    out_if.msg_ready_and = 1'b0;
    e.h = mk_hdr(T_WR, 3'd6, 40'h00_0000_4000, 64'h2);
    e.d = {64'h107, 64'h106, 64'h105, 64'h104, 64'h103, 64'h102, 64'h101, 64'h100};
    exp_q.push_back(e);
    send_msg(T_WR, 3'd6, 40'h00_0000_4000, 64'h2, 8, 64'h100, 64'h1, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_v_held", OUT_W'(out_if.msg_v), OUT_W'(1'b1));
      chk("bp_ready_low", OUT_W'(in_if.msg_ready_and), OUT_W'(1'b0));
      chk("bp_header_stable", OUT_W'(out_if.msg_header), OUT_W'(e.h));
      chk("bp_data_stable", out_if.msg_data, e.d);
    end
    base_x = n_xfer;
    @(posedge clk); #1;
    out_if.msg_ready_and = 1'b1;
    @(posedge clk); #1;
    chk_i("bp_xfer_on_6th", n_xfer, base_x + 1);

    // Reset after 3 of 8 beats, then a clean 8-beat write
    send_msg(T_WR, 3'd6, 40'h00_0000_5000, 64'h3, 3, 64'hDEAD, 64'h1, 0);
    reset_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("midreset");
    @(posedge clk); #1;
    reset_n = 1'b1;
    e.h = mk_hdr(T_WR, 3'd6, 40'h00_0000_6000, 64'h4);
    e.d = {64'hA7, 64'hA6, 64'hA5, 64'hA4, 64'hA3, 64'hA2, 64'hA1, 64'hA0};
    exp_q.push_back(e);
    send_msg(T_WR, 3'd6, 40'h00_0000_6000, 64'h4, 8, 64'hA0, 64'h1, 0);
    @(negedge clk);
    chk("after_reset_latency_v", OUT_W'(out_if.msg_v), OUT_W'(1'b1));
    @(posedge clk); #1;

    // Ten 8B reads back-to-back: throughput
    xfer_cyc.delete();
    for (int i = 0; i < 10; i++) begin
      e.h = mk_hdr(T_RD, 3'd3, PADDR_W'(40'h7000 + i * 8), 64'h9);
      e.d = OUT_W'(64'hB0 + 64'(i));
      exp_q.push_back(e);
    end
    for (int i = 0; i < 10; i++) begin
      drive_beat(mk_hdr(T_RD, 3'd3, PADDR_W'(40'h7000 + i * 8), 64'h9), 64'hB0 + 64'(i));
    end
    for (int i = 0; i < 50 && xfer_cyc.size() < 10; i++) @(posedge clk);
    chk_i("tput_count", xfer_cyc.size(), 10);
    for (int i = 1; i < xfer_cyc.size(); i++) begin
      chk_i("tput_gap", xfer_cyc[i] - xfer_cyc[i-1], EXP_GAP);
    end

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
    chk_i("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
